// File: rtl/rocketcpu_wb_debug_master.sv
// Byte-stream command bridge: 'W' adr[4] dat[4] / 'R' adr[4] from the UART side
// become a single Wishbone access; the result goes back as 'K', 'E' or 4 data bytes.
module rocketcpu_wb_debug_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_wb_clk,
  input  logic        reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_busy
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt;
  logic [1:0]  tx_idx;
  logic [TW-1:0] tmo;
  logic        err;
  logic [31:0] rdata;
  logic        rx_cmd;
  logic        rx_last;
  logic        tmo_hit;
  logic        tx_last;

  assign rx_cmd  = i_rx_valid && (i_rx_data == 8'h57 || i_rx_data == 8'h52);
  assign rx_last = i_rx_valid && (cnt == 2'd3);
  // The last allowed BUS cycle is the one where tmo == TIMEOUT-1; an ack there still wins.
  assign tmo_hit = !i_wb_ack && (tmo == TMO_LAST);
  assign tx_last = err || o_wb_we || (tx_idx == 2'd3);

  always_ff @(posedge i_wb_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rx_cmd) state_nxt = ADDR;
      ADDR: if (rx_last) state_nxt = o_wb_we ? DATA : BUS;
      DATA: if (rx_last) state_nxt = BUS;
      BUS:  if (i_wb_ack || tmo_hit) state_nxt = RESP;
      RESP: if (i_tx_ready && tx_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_wb_clk) begin
    if (reset) begin
      cnt      <= '0;
      tx_idx   <= '0;
      tmo      <= '0;
      err      <= 1'b0;
      rdata    <= '0;
      o_wb_adr <= '0;
      o_wb_dat <= '0;
      o_wb_we  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt    <= '0;
          tmo    <= '0;
          tx_idx <= '0;
          err    <= 1'b0;
          if (rx_cmd) o_wb_we <= (i_rx_data == 8'h57);
        end
        ADDR: if (i_rx_valid) begin
          o_wb_adr[{cnt, 3'b000} +: 8] <= i_rx_data;
          cnt <= cnt + 2'd1;
        end
        DATA: if (i_rx_valid) begin
          o_wb_dat[{cnt, 3'b000} +: 8] <= i_rx_data;
          cnt <= cnt + 2'd1;
        end
        BUS: begin
          if (i_wb_ack) begin
            rdata <= i_wb_rdt;
          end else begin
            tmo <= tmo + 1'b1;
            err <= tmo_hit;
          end
        end
        RESP: if (i_tx_ready) tx_idx <= tx_idx + 2'd1;
        default: ;
      endcase
    end
  end

  assign o_wb_cyc   = (state == BUS);
  assign o_wb_sel   = o_wb_cyc ? 4'hF : 4'h0;
  assign o_busy     = (state != IDLE);
  assign o_tx_valid = (state == RESP);

  always_comb begin
    o_tx_data = '0;
    if (state == RESP) begin
      if (err)          o_tx_data = 8'h45;
      else if (o_wb_we) o_tx_data = 8'h4B;
      else              o_tx_data = rdata[{tx_idx, 3'b000} +: 8];
    end
  end

endmodule

// File: tb/tb_rocketcpu_wb_debug_master.sv
// Randomised scoreboard bench for the UART-to-Wishbone debug bridge.
module tb_rocketcpu_wb_debug_master;

  localparam int TIMEOUT = 255;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    int          len;
  } bus_t;

  logic        i_wb_clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b1;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt = '0;
  logic        i_wb_ack = 1'b0;
  logic        o_busy;

  rocketcpu_wb_debug_master #(.TIMEOUT(TIMEOUT)) dut (
    .i_wb_clk(i_wb_clk), .reset(reset),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc),
    .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack), .o_busy(o_busy)
  );

  always #5 i_wb_clk = ~i_wb_clk;

  int checks = 0;
  int errors = 0;

  bus_t        bus_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  pend[$];

  int          ack_delay = 0;      // -1: slave never acks
  logic [31:0] rdt_val = '0;
  logic        stall_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: acks in cycle ack_delay+1 of the cycle; rdt is junk outside the ack cycle.
  int slave_cnt = 0;
  always @(negedge i_wb_clk) begin
    if (o_wb_cyc && !reset) begin
      slave_cnt++;
      i_wb_ack = (ack_delay >= 0) && (slave_cnt == ack_delay + 1);
    end else begin
      slave_cnt = 0;
      i_wb_ack = 1'b0;
    end
    i_wb_rdt = i_wb_ack ? rdt_val : $urandom;
  end

  always @(posedge i_wb_clk) begin
    #1;
    i_tx_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: compares bus cycles and accepted tx bytes against the scoreboard queues.
  logic        in_cyc = 1'b0;
  int          cyc_len = 0;
  logic        stable = 1'b1;
  bus_t        cur;
  logic [31:0] f_adr, f_dat;
  logic        f_we;
  logic        stall_pend = 1'b0;
  logic [7:0]  stall_data = '0;

  always @(negedge i_wb_clk) begin
    if (reset) begin
      in_cyc = 1'b0;
      stall_pend = 1'b0;
    end else begin
      if (o_wb_cyc) begin
        if (!in_cyc) begin
          in_cyc = 1'b1;
          cyc_len = 1;
          stable = 1'b1;
          f_adr = o_wb_adr; f_dat = o_wb_dat; f_we = o_wb_we;
          if (bus_q.size() == 0) begin
            cur.len = -1;
            check("unexpected_cyc", 32'd1, 32'd0);
          end else begin
            cur = bus_q.pop_front();
            check("bus_adr", o_wb_adr, cur.adr);
            check("bus_we", 32'(o_wb_we), 32'(cur.we));
            check("bus_sel", 32'(o_wb_sel), 32'hF);
            if (cur.we) check("bus_dat", o_wb_dat, cur.dat);
          end
        end else begin
          cyc_len++;
          if (o_wb_adr !== f_adr || o_wb_dat !== f_dat || o_wb_we !== f_we || o_wb_sel !== 4'hF)
            stable = 1'b0;
        end
      end else if (in_cyc) begin
        in_cyc = 1'b0;
        check("bus_stable", 32'(stable), 32'd1);
        if (cur.len >= 0) check("cyc_len", 32'(cyc_len), 32'(cur.len));
      end

      if (stall_pend) begin
        stall_pend = 1'b0;
        check("tx_hold", {23'd0, o_tx_valid, o_tx_data}, {23'd0, 1'b1, stall_data});
      end
      if (o_tx_valid) begin
        if (i_tx_ready) begin
          if (tx_q.size() == 0) check("unexpected_tx", {24'd0, o_tx_data}, 32'hFFFF_FFFF);
          else check("tx_byte", {24'd0, o_tx_data}, {24'd0, tx_q.pop_front()});
        end else begin
          stall_pend = 1'b1;
          stall_data = o_tx_data;
        end
      end
    end
  end

  // Reference model: a command is a 'W' + 8 bytes or 'R' + 4 bytes; stray bytes outside a
  // command are ignored. d = -2 marks a command that will be cut short by reset.
  task automatic model_byte(input logic [7:0] b, input int d, input logic [31:0] rv);
    bus_t t;
    logic ok;
    if (pend.size() == 0 && b != 8'h57 && b != 8'h52) return;
    pend.push_back(b);
    if ((pend[0] == 8'h57 && pend.size() == 9) || (pend[0] == 8'h52 && pend.size() == 5)) begin
      t.we  = (pend[0] == 8'h57);
      t.adr = {pend[4], pend[3], pend[2], pend[1]};
      t.dat = t.we ? {pend[8], pend[7], pend[6], pend[5]} : 32'd0;
      ok    = (d >= 0) && (d < TIMEOUT);
      t.len = (d == -2) ? -1 : (ok ? d + 1 : TIMEOUT);
      bus_q.push_back(t);
      if (d != -2) begin
        if (!ok) tx_q.push_back(8'h45);
        else if (t.we) tx_q.push_back(8'h4B);
        else for (int i = 0; i < 4; i++) tx_q.push_back(rv[8*i +: 8]);
      end
      pend.delete();
    end
  endtask

  // All drive tasks start and end one time unit after a rising edge.
  task automatic drive_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_valid = 1'b1;
    @(posedge i_wb_clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 2000) begin
      @(posedge i_wb_clk); #1;
      n++;
    end
    check("idle_timeout", 32'(o_busy), 32'd0);
  endtask

  task automatic noise_while_busy(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      if (!o_busy) break;
      b = 8'($urandom);
      if ((i & 1) == 0) b = 8'h57;
      drive_byte(b);
    end
  endtask

  task automatic run_cmd(input byte_q_t bytes, input int d, input logic [31:0] rv,
                         input int noise, input logic gaps);
    ack_delay = d;
    rdt_val = rv;
    foreach (bytes[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge i_wb_clk); #1;
      end
      model_byte(bytes[i], d, rv);
      drive_byte(bytes[i]);
    end
    noise_while_busy(noise);
    wait_idle();
  endtask

  function automatic byte_q_t mk_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    byte_q_t q;
    q.push_back(we ? 8'h57 : 8'h52);
    for (int i = 0; i < 4; i++) q.push_back(adr[8*i +: 8]);
    if (we) for (int i = 0; i < 4; i++) q.push_back(dat[8*i +: 8]);
    return q;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t q;
    int n;
    repeat (3) @(posedge i_wb_clk);
    @(negedge i_wb_clk);
    check("rst_cyc", 32'(o_wb_cyc), 32'd0);
    check("rst_we", 32'(o_wb_we), 32'd0);
    check("rst_txv", 32'(o_tx_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_adr", o_wb_adr, 32'd0);
    check("rst_dat", o_wb_dat, 32'd0);
    check("rst_txd", 32'(o_tx_data), 32'd0);
    @(posedge i_wb_clk); #1;
    reset = 1'b0;

    q = '{8'h00, 8'h41};
    run_cmd(q, 0, 0, 0, 1'b0);
    check("noise_idle", 32'(o_busy), 32'd0);

    run_cmd(mk_cmd(1'b1, 32'h0000_0000, 32'hDEAD_BEEF), 1, 0, 0, 1'b0);

    stall_mode = 1'b1;
    run_cmd(mk_cmd(1'b0, 32'h0010_0000, 32'h0), 2, 32'h1234_5678, 0, 1'b0);

    run_cmd(mk_cmd(1'b0, 32'h0700_0000, 32'h0), -1, 32'h0, 6, 1'b0);
    run_cmd(mk_cmd(1'b1, 32'hCAFE_0004, 32'h0BAD_F00D), TIMEOUT - 1, 0, 3, 1'b0);
    run_cmd(mk_cmd(1'b0, 32'h0000_0FF0, 32'h0), TIMEOUT, 32'hA5A5_5A5A, 3, 1'b0);

    for (int k = 0; k < 30; k++) begin
      q.delete();
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'h57 || b == 8'h52) b = b ^ 8'h01;
        q.push_back(b);
      end
      q = {q, mk_cmd(1'($urandom_range(0, 1)), $urandom, $urandom)};
      stall_mode = 1'($urandom_range(0, 1));
      run_cmd(q, $urandom_range(0, 8), $urandom, $urandom_range(0, 4), 1'b1);
    end

    stall_mode = 1'b0;
    ack_delay = -1;
    q = mk_cmd(1'b1, 32'h1111_2222, 32'h3333_4444);
    foreach (q[i]) begin
      model_byte(q[i], -2, 0);
      drive_byte(q[i]);
    end
    n = 0;
    while (!o_wb_cyc && n < 20) begin
      @(posedge i_wb_clk); #1;
      n++;
    end
    check("cyc_before_reset", 32'(o_wb_cyc), 32'd1);
    @(posedge i_wb_clk); @(posedge i_wb_clk); #1;
    reset = 1'b1;
    @(posedge i_wb_clk); #1;
    check("abort_cyc", 32'(o_wb_cyc), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_txv", 32'(o_tx_valid), 32'd0);
    reset = 1'b0;
    run_cmd(mk_cmd(1'b1, 32'h8000_0010, 32'h0102_0304), 0, 0, 0, 1'b0);

    repeat (5) @(posedge i_wb_clk);
    #1;
    check("bus_q_empty", 32'(bus_q.size()), 32'd0);
    check("tx_q_empty", 32'(tx_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rocketcpu_wb_debug_master.md
ROCKETCPU_WB_DEBUG_MASTER -- requirements
Module: rocketcpu_wb_debug_master

Purpose: byte-stream command bridge (fed by UART RX/TX byte ports) acting as Wishbone initiator on the memory bus; used for host-side peek/poke and firmware load.

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL be the maximum number of cycles a bus access waits for i_wb_ack before aborting.
REQ-002 i_wb_clk  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_rx_data  input  8  received command byte.
REQ-005 i_rx_valid  input  1  one-cycle strobe qualifying i_rx_data; no backpressure.
REQ-006 o_tx_data  output  8  response byte.
REQ-007 o_tx_valid  output  1  response byte valid.
REQ-008 i_tx_ready  input  1  transmitter accepts o_tx_data when o_tx_valid && i_tx_ready.
REQ-009 o_wb_adr  output  32  bus address.
REQ-010 o_wb_dat  output  32  write data.
REQ-011 o_wb_sel  output  4  byte select; SHALL be 4'b1111 whenever o_wb_cyc is high.
REQ-012 o_wb_we  output  1  write enable.
REQ-013 o_wb_cyc  output  1  cycle request (bus has no separate stb).
REQ-014 i_wb_rdt  input  32  read data, valid in the i_wb_ack cycle.
REQ-015 i_wb_ack  input  1  transfer acknowledge.
REQ-016 o_busy  output  1  high in every state except IDLE.

Function
REQ-017 States SHALL be IDLE, ADDR, DATA, BUS, RESP.
REQ-018 IDLE: rx byte 0x57 ('W') -> ADDR with we=1; 0x52 ('R') -> ADDR with we=0; any other byte ignored, stay IDLE.
REQ-019 ADDR: collect 4 rx bytes, little-endian (first byte -> adr[7:0]); after 4th byte go DATA if we=1, else BUS.
REQ-020 DATA: collect 4 rx bytes little-endian into o_wb_dat; after 4th byte go BUS.
REQ-021 Byte counter SHALL be 2 bits, cleared on every state entry, wrapping 3->0 on the state-transition byte.
REQ-022 BUS: o_wb_cyc high from the first cycle in BUS, o_wb_adr/o_wb_dat/o_wb_we stable while cyc high; cyc SHALL drop the cycle after i_wb_ack is seen.
REQ-023 On i_wb_ack in BUS, read data SHALL be captured from i_wb_rdt in that same cycle; then go RESP.
REQ-024 Timeout counter SHALL start at 0 on BUS entry and increment each BUS cycle without ack; when it reaches TIMEOUT without ack, drop cyc and go RESP with error flag set.
REQ-025 An ack arriving in the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-026 RESP, error: send single byte 0x45 ('E').
REQ-027 RESP, write success: send single byte 0x4B ('K').
REQ-028 RESP, read success: send 4 bytes of captured data, little-endian (rdt[7:0] first).
REQ-029 o_tx_valid SHALL stay high with o_tx_data stable until accepted; next byte presented the cycle after acceptance; after the last accepted byte go IDLE.
REQ-030 Rx bytes arriving in BUS or RESP SHALL be dropped, with no effect on state.
REQ-031 Back-to-back commands: a byte arriving the cycle after return to IDLE SHALL be decoded normally.
REQ-032 No inter-byte timeout; partial commands wait indefinitely (host resyncs via reset).

Reset
REQ-033 While reset is high: state IDLE, o_wb_cyc=0, o_wb_we=0, o_tx_valid=0, o_busy=0, o_wb_adr=0, o_wb_dat=0, o_tx_data=0, counters and error flag 0.
REQ-034 Reset asserted mid-command or mid-BUS SHALL abort immediately: cyc dropped in the cycle after reset is sampled, and no response is sent.

Verification
REQ-035 Write: rx 57,00,00,00,00,EF,BE,AD,DE; ack after 1 cycle -> one cyc with adr=0x00000000, dat=0xDEADBEEF, we=1, sel=F; tx 0x4B.
REQ-036 Read: rx 52,00,00,10,00; slave acks with rdt=0x12345678 -> adr=0x00100000, we=0; tx 78,56,34,12 in order, with i_tx_ready toggling to exercise stalls.
REQ-037 Timeout: rx 52,00,00,00,07 with no ack -> cyc high exactly TIMEOUT cycles, then tx 0x45, return to IDLE.
REQ-038 Noise and drop: rx 0x00,0x41 in IDLE -> no state change; extra rx bytes during BUS/RESP -> ignored, response unchanged.
REQ-039 Reset mid-transfer: assert reset while cyc is high -> cyc=0 and o_busy=0 the next cycle, no tx; a following write command completes normally.
